// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port (I) and a memory-stage port (D) onto one memory port.
// One transaction is in flight at a time; D wins ties until I has waited STARVE_LIMIT grants.
module mem_arbiter #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ireq_i,
  input  logic [ADDR_WIDTH-1:0] iaddr_i,
  output logic [DATA_WIDTH-1:0] irdata_o,
  output logic                  ivalid_o,
  output logic                  istall_o,
  input  logic                  dreq_i,
  input  logic                  dwe_i,
  input  logic [ADDR_WIDTH-1:0] daddr_i,
  input  logic [DATA_WIDTH-1:0] dwdata_i,
  input  logic [3:0]            dbyteen_i,
  output logic [DATA_WIDTH-1:0] drdata_o,
  output logic                  dvalid_o,
  output logic                  dstall_o,
  output logic                  mreq_o,
  output logic                  mwe_o,
  output logic [ADDR_WIDTH-1:0] maddr_o,
  output logic [DATA_WIDTH-1:0] mwdata_o,
  output logic [3:0]            mbyteen_o,
  input  logic                  mready_i,
  input  logic                  mrvalid_i,
  input  logic [DATA_WIDTH-1:0] mrdata_i
);

  localparam int unsigned CntW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] Limit = CntW'(STARVE_LIMIT);

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e                r_state, w_state_d;
  logic                  r_own_i;
  logic [CntW-1:0]       r_starve, w_starve_d;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [3:0]            r_byteen;
  logic [DATA_WIDTH-1:0] r_irdata, r_drdata;
  logic                  r_ivalid, r_dvalid;
  logic                  w_i_elig, w_d_elig;
  logic                  w_grant_i, w_grant_d;
  logic                  w_done;

  // A side that is completing this cycle must not be regranted in the same cycle.
  assign w_i_elig = ireq_i & ~r_ivalid;
  assign w_d_elig = dreq_i & ~r_dvalid;
  assign w_done   = (r_state == StWait) & mrvalid_i;

  always_comb begin
    w_state_d  = r_state;
    w_starve_d = r_starve;
    w_grant_i  = 1'b0;
    w_grant_d  = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_d_elig && (!w_i_elig || (r_starve < Limit))) begin
          w_grant_d = 1'b1;
          w_state_d = StReq;
          if (ireq_i) begin
            w_starve_d = (r_starve == Limit) ? Limit : r_starve + 1'b1;
          end else begin
            w_starve_d = '0;
          end
        end else if (w_i_elig) begin
          w_grant_i  = 1'b1;
          w_state_d  = StReq;
          w_starve_d = '0;
        end
      end
      StReq: begin
        if (mready_i) w_state_d = StWait;
      end
      StWait: begin
        if (mrvalid_i) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= StIdle;
      r_own_i  <= 1'b0;
      r_starve <= '0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_byteen <= '0;
      r_irdata <= '0;
      r_drdata <= '0;
      r_ivalid <= 1'b0;
      r_dvalid <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_starve <= w_starve_d;
      r_ivalid <= w_done & r_own_i;
      r_dvalid <= w_done & ~r_own_i;
      if (w_grant_d) begin
        r_own_i  <= 1'b0;
        r_we     <= dwe_i;
        r_addr   <= daddr_i;
        r_wdata  <= dwdata_i;
        r_byteen <= dbyteen_i;
      end else if (w_grant_i) begin
        r_own_i  <= 1'b1;
        r_we     <= 1'b0;
        r_addr   <= iaddr_i;
        r_wdata  <= '0;
        r_byteen <= 4'hF;
      end
      if (w_done) begin
        if (r_own_i) r_irdata <= mrdata_i;
        else         r_drdata <= mrdata_i;
      end
    end
  end

  assign mreq_o    = (r_state == StReq);
  assign mwe_o     = r_we;
  assign maddr_o   = r_addr;
  assign mwdata_o  = r_wdata;
  assign mbyteen_o = r_byteen;
  assign irdata_o  = r_irdata;
  assign drdata_o  = r_drdata;
  assign ivalid_o  = r_ivalid;
  assign dvalid_o  = r_dvalid;
  assign istall_o  = ireq_i & ~r_ivalid;
  assign dstall_o  = dreq_i & ~r_dvalid;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a per-cycle vector table plus hand-written
// sequences for starvation, reset during WAIT and back-to-back D requests.
module tb_mem_arbiter;

  logic        clk, rst;
  logic        ireq_i, ivalid_o, istall_o;
  logic [31:0] iaddr_i, irdata_o;
  logic        dreq_i, dwe_i, dvalid_o, dstall_o;
  logic [31:0] daddr_i, dwdata_i, drdata_o;
  logic [3:0]  dbyteen_i, mbyteen_o;
  logic        mreq_o, mwe_o, mready_i, mrvalid_i;
  logic [31:0] maddr_o, mwdata_o, mrdata_i;

  int n_checks = 0;
  int n_errors = 0;

  mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .ireq_i(ireq_i), .iaddr_i(iaddr_i), .irdata_o(irdata_o), .ivalid_o(ivalid_o),
    .istall_o(istall_o),
    .dreq_i(dreq_i), .dwe_i(dwe_i), .daddr_i(daddr_i), .dwdata_i(dwdata_i),
    .dbyteen_i(dbyteen_i), .drdata_o(drdata_o), .dvalid_o(dvalid_o), .dstall_o(dstall_o),
    .mreq_o(mreq_o), .mwe_o(mwe_o), .maddr_o(maddr_o), .mwdata_o(mwdata_o),
    .mbyteen_o(mbyteen_o), .mready_i(mready_i), .mrvalid_i(mrvalid_i), .mrdata_i(mrdata_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, ireq, dreq, dwe, mready, mrvalid;
    logic [31:0] iaddr, daddr, dwdata, mrdata;
    logic [3:0]  dbe;
    logic        e_mreq, e_mwe, e_ivalid, e_dvalid, e_istall, e_dstall, chk;
    logic [31:0] e_maddr, e_mwdata, e_irdata, e_drdata;
    logic [3:0]  e_mbe;
  } vec_t;

  vec_t tbl[$];
  vec_t cur;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    rst = 0; ireq_i = 0; iaddr_i = 0; dreq_i = 0; dwe_i = 0; daddr_i = 0;
    dwdata_i = 0; dbyteen_i = 0; mready_i = 0; mrvalid_i = 0; mrdata_i = 0;
  endtask

  // Both sides request; both drop in the completion cycle and re-raise next round.
  task automatic starve_round(input int r, input logic exp_i);
    string tag;
    tag = $sformatf("starve%0d", r);
    ireq_i = 1; iaddr_i = 32'h300; dreq_i = 1; dwe_i = 0; daddr_i = 32'h500;
    dbyteen_i = 4'hF; mready_i = 0; mrvalid_i = 0;
    #1 chk({tag, " idle mreq"}, 32'(mreq_o), 0);
    @(negedge clk);
    mready_i = 1;
    #1 chk({tag, " mreq"}, 32'(mreq_o), 1);
    chk({tag, " owner addr"}, maddr_o, exp_i ? 32'h300 : 32'h500);
    @(negedge clk);
    mready_i = 0; mrvalid_i = 1; mrdata_i = 32'(r);
    @(negedge clk);
    mrvalid_i = 0; ireq_i = 0; dreq_i = 0;
    #1 chk({tag, " ivalid"}, 32'(ivalid_o), 32'(exp_i));
    chk({tag, " dvalid"}, 32'(dvalid_o), 32'(!exp_i));
    @(negedge clk);
  endtask

  initial begin
    clk = 0;
    idle_inputs();
    rst = 1;

    cur = '{default: '0};
    cur.rst = 1; tbl.push_back(cur);
    cur.rst = 0; cur.chk = 1; tbl.push_back(cur);
    // Fetch only
    cur.ireq = 1; cur.iaddr = 32'h100; cur.e_istall = 1; tbl.push_back(cur);
    cur.mready = 1; cur.e_mreq = 1; cur.e_maddr = 32'h100; cur.e_mbe = 4'hF; tbl.push_back(cur);
    cur.mready = 0; cur.mrvalid = 1; cur.mrdata = 32'h00500093; cur.e_mreq = 0; tbl.push_back(cur);
    cur.mrvalid = 0; cur.mrdata = 0; cur.e_ivalid = 1; cur.e_irdata = 32'h00500093;
    cur.e_istall = 0; tbl.push_back(cur);
    cur.ireq = 0; cur.e_ivalid = 0; tbl.push_back(cur);
    // Contention: D read 0x2000 served before I fetch 0x104
    cur.ireq = 1; cur.iaddr = 32'h104; cur.dreq = 1; cur.daddr = 32'h2000; cur.dbe = 4'hF;
    cur.e_istall = 1; cur.e_dstall = 1; tbl.push_back(cur);
    cur.mready = 1; cur.e_mreq = 1; cur.e_maddr = 32'h2000; cur.e_mbe = 4'hF; tbl.push_back(cur);
    cur.mready = 0; cur.mrvalid = 1; cur.mrdata = 32'h11112222; cur.e_mreq = 0; tbl.push_back(cur);
    cur.mrvalid = 0; cur.e_dvalid = 1; cur.e_drdata = 32'h11112222; cur.e_dstall = 0;
    tbl.push_back(cur);
    cur.dreq = 0; cur.e_dvalid = 0; cur.e_mreq = 1; cur.e_maddr = 32'h104; tbl.push_back(cur);
    cur.mready = 1; tbl.push_back(cur);
    cur.mready = 0; cur.mrvalid = 1; cur.mrdata = 32'h33334444; cur.e_mreq = 0; tbl.push_back(cur);
    cur.mrvalid = 0; cur.e_ivalid = 1; cur.e_irdata = 32'h33334444; cur.e_istall = 0;
    tbl.push_back(cur);
    cur.ireq = 0; cur.e_ivalid = 0; tbl.push_back(cur);
    // Backpressure: D write held in REQ for 6 cycles; stray mrvalid in REQ ignored
    cur.dreq = 1; cur.dwe = 1; cur.daddr = 32'h40; cur.dwdata = 32'hDEADBEEF; cur.dbe = 4'b0011;
    cur.e_dstall = 1; tbl.push_back(cur);
    cur.mrvalid = 1; cur.mrdata = 32'hBAD0BAD0; cur.e_mreq = 1; cur.e_mwe = 1;
    cur.e_maddr = 32'h40; cur.e_mwdata = 32'hDEADBEEF; cur.e_mbe = 4'b0011; tbl.push_back(cur);
    cur.mrvalid = 0; tbl.push_back(cur);
    cur.daddr = 32'h44; tbl.push_back(cur);
    tbl.push_back(cur);
    tbl.push_back(cur);
    cur.mready = 1; tbl.push_back(cur);
    cur.e_mreq = 0; tbl.push_back(cur);
    cur.mready = 0; cur.mrvalid = 1; cur.mrdata = 32'hA5A5A5A5; tbl.push_back(cur);
    cur.mrvalid = 0; cur.e_dvalid = 1; cur.e_drdata = 32'hA5A5A5A5; cur.e_dstall = 0;
    tbl.push_back(cur);
    // mrvalid in IDLE must not disturb held read data
    cur.dreq = 0; cur.dwe = 0; cur.daddr = 0; cur.dwdata = 0; cur.dbe = 0;
    cur.mrvalid = 1; cur.mrdata = 32'hFFFFFFFF; cur.e_dvalid = 0; tbl.push_back(cur);
    cur.mrvalid = 0; tbl.push_back(cur);

    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst; ireq_i = tbl[i].ireq; iaddr_i = tbl[i].iaddr;
      dreq_i = tbl[i].dreq; dwe_i = tbl[i].dwe; daddr_i = tbl[i].daddr;
      dwdata_i = tbl[i].dwdata; dbyteen_i = tbl[i].dbe;
      mready_i = tbl[i].mready; mrvalid_i = tbl[i].mrvalid; mrdata_i = tbl[i].mrdata;
      #1;
      if (tbl[i].chk) begin
        chk($sformatf("c%0d mreq", i), 32'(mreq_o), 32'(tbl[i].e_mreq));
        chk($sformatf("c%0d ivalid", i), 32'(ivalid_o), 32'(tbl[i].e_ivalid));
        chk($sformatf("c%0d dvalid", i), 32'(dvalid_o), 32'(tbl[i].e_dvalid));
        chk($sformatf("c%0d irdata", i), irdata_o, tbl[i].e_irdata);
        chk($sformatf("c%0d drdata", i), drdata_o, tbl[i].e_drdata);
        chk($sformatf("c%0d istall", i), 32'(istall_o), 32'(tbl[i].e_istall));
        chk($sformatf("c%0d dstall", i), 32'(dstall_o), 32'(tbl[i].e_dstall));
        if (tbl[i].e_mreq) begin
          chk($sformatf("c%0d mwe", i), 32'(mwe_o), 32'(tbl[i].e_mwe));
          chk($sformatf("c%0d maddr", i), maddr_o, tbl[i].e_maddr);
          chk($sformatf("c%0d mwdata", i), mwdata_o, tbl[i].e_mwdata);
          chk($sformatf("c%0d mbyteen", i), 32'(mbyteen_o), 32'(tbl[i].e_mbe));
        end
        if (i == 1) begin
          chk("reset maddr", maddr_o, 0);
          chk("reset mwdata", mwdata_o, 0);
        end
      end
      @(negedge clk);
    end

    // Starvation: four D wins while I waits, then I, then the count restarts
    idle_inputs();
    starve_round(0, 1'b0);
    starve_round(1, 1'b0);
    starve_round(2, 1'b0);
    starve_round(3, 1'b0);
    starve_round(4, 1'b1);
    starve_round(5, 1'b0);

    // Reset during WAIT; the late mrvalid must be discarded
    idle_inputs();
    dreq_i = 1; daddr_i = 32'h600; dbyteen_i = 4'hF;
    @(negedge clk);
    mready_i = 1;
    @(negedge clk);
    mready_i = 0; rst = 1;
    #1 chk("rstwait in WAIT mreq", 32'(mreq_o), 0);
    @(negedge clk);
    rst = 0; dreq_i = 0; mrvalid_i = 1; mrdata_i = 32'hCAFEF00D;
    #1 chk("rstwait mreq", 32'(mreq_o), 0);
    chk("rstwait maddr", maddr_o, 0);
    chk("rstwait drdata", drdata_o, 0);
    chk("rstwait irdata", irdata_o, 0);
    @(negedge clk);
    mrvalid_i = 0;
    #1 chk("rstwait dvalid", 32'(dvalid_o), 0);
    chk("rstwait ivalid", 32'(ivalid_o), 0);
    chk("rstwait drdata held", drdata_o, 0);
    chk("rstwait still idle", 32'(mreq_o), 0);
    ireq_i = 1; iaddr_i = 32'h700;
    @(negedge clk);
    mready_i = 1;
    #1 chk("post-rst mreq", 32'(mreq_o), 1);
    chk("post-rst maddr", maddr_o, 32'h700);
    @(negedge clk);
    mready_i = 0; mrvalid_i = 1; mrdata_i = 32'h12345678;
    @(negedge clk);
    mrvalid_i = 0;
    #1 chk("post-rst ivalid", 32'(ivalid_o), 1);
    chk("post-rst irdata", irdata_o, 32'h12345678);
    chk("post-rst istall", 32'(istall_o), 0);
    ireq_i = 0;
    @(negedge clk);

    // Back-to-back: dreq held through dvalid with a new address
    idle_inputs();
    dreq_i = 1; daddr_i = 32'h800; dbyteen_i = 4'hF;
    @(negedge clk);
    mready_i = 1;
    #1 chk("b2b first maddr", maddr_o, 32'h800);
    @(negedge clk);
    mready_i = 0; mrvalid_i = 1; mrdata_i = 32'h0BADCAFE;
    @(negedge clk);
    mrvalid_i = 0; daddr_i = 32'h804;
    #1 chk("b2b dvalid", 32'(dvalid_o), 1);
    chk("b2b drdata", drdata_o, 32'h0BADCAFE);
    chk("b2b dstall in valid", 32'(dstall_o), 0);
    chk("b2b mreq in valid", 32'(mreq_o), 0);
    @(negedge clk);
    #1 chk("b2b dvalid drop", 32'(dvalid_o), 0);
    chk("b2b mreq grant cycle", 32'(mreq_o), 0);
    chk("b2b dstall", 32'(dstall_o), 1);
    @(negedge clk);
    #1 chk("b2b second mreq", 32'(mreq_o), 1);
    chk("b2b second maddr", maddr_o, 32'h804);
    mready_i = 1;
    @(negedge clk);
    mready_i = 0; mrvalid_i = 1; mrdata_i = 32'h5555AAAA;
    @(negedge clk);
    mrvalid_i = 0;
    #1 chk("b2b second dvalid", 32'(dvalid_o), 1);
    chk("b2b second drdata", drdata_o, 32'h5555AAAA);
    dreq_i = 0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, default 32, data bus width; ADDR_WIDTH, default 32, address width; STARVE_LIMIT, default 4, maximum consecutive D grants while I waits.
REQ-002 SHALL have ports, one per line as follows:
 clk  in  1  single clock, rising edge
 rst  in  1  reset, synchronous and active-high
 ireq_i  in  1  fetch-side read request, held until ivalid_o
 iaddr_i  in  ADDR_WIDTH  fetch address
 irdata_o  out  DATA_WIDTH  fetch read data
 ivalid_o  out  1  fetch completion pulse
 istall_o  out  1  fetch stall (drives PC/F-D enable low)
 dreq_i  in  1  memory-stage request, held until dvalid_o
 dwe_i  in  1  1=write, 0=read
 daddr_i  in  ADDR_WIDTH  data address
 dwdata_i  in  DATA_WIDTH  write data
 dbyteen_i  in  4  byte enables
 drdata_o  out  DATA_WIDTH  load data
 dvalid_o  out  1  data completion pulse
 dstall_o  out  1  pipeline stall for M stage and earlier
 mreq_o  out  1  unified memory request
 mwe_o  out  1  memory write enable
 maddr_o  out  ADDR_WIDTH  memory address
 mwdata_o  out  DATA_WIDTH  memory write data
 mbyteen_o  out  4  memory byte enables
 mready_i  in  1  memory accepts request this cycle
 mrvalid_i  in  1  memory completion (reads and writes)
 mrdata_i  in  DATA_WIDTH  memory read data

Function
REQ-003 SHALL implement FSM states IDLE, REQ, WAIT, with owner register OWN in {I, D}.
REQ-004 SHALL, in IDLE, arbitrate among eligible requesters; a side is eligible if its req_i is 1 and its valid_o is 0 this cycle.
REQ-005 SHALL grant D when only D is eligible, or when both are eligible and STARVE_CNT < STARVE_LIMIT.
REQ-006 SHALL grant I when only I is eligible, or when both are eligible and STARVE_CNT == STARVE_LIMIT.
REQ-007 SHALL, on a grant, latch address/we/wdata/byteen of the winner (I: we=0, byteen=4'hF), set OWN, and move to REQ.
REQ-008 SHALL increment STARVE_CNT on a D grant when ireq_i is 1; it SHALL clear to 0 on any I grant, and on a D grant when ireq_i is 0; it SHALL saturate at STARVE_LIMIT.
REQ-009 SHALL drive mreq_o=1 only in REQ; m* outputs SHALL come from the latched registers and stay stable while mreq_o=1.
REQ-010 SHALL move REQ->WAIT when mready_i=1; mreq_o SHALL stay 1 indefinitely while mready_i=0.
REQ-011 SHALL move WAIT->IDLE when mrvalid_i=1, capture mrdata_i into the owner's rdata_o, and assert the owner's valid_o for exactly the next cycle.
REQ-012 SHALL hold irdata_o/drdata_o stable until the next completion for that side.
REQ-013 SHALL ignore mrvalid_i in IDLE and REQ; mready_i SHALL be ignored outside REQ.
REQ-014 SHALL assert istall_o = ireq_i & ~ivalid_o and dstall_o = dreq_i & ~dvalid_o, combinationally.
REQ-015 SHALL keep one transaction outstanding at most; minimum latency, request to valid_o, is 3 cycles (grant, REQ with mready_i=1, WAIT with mrvalid_i=1).
REQ-016 SHALL not change a latched request when req_i inputs change mid-transaction.

Reset
REQ-017 SHALL, on rst=1 at a clock edge, force IDLE, OWN=D, STARVE_CNT=0, mreq_o=0, ivalid_o=0, dvalid_o=0, and irdata_o=drdata_o=m* data/address=0, including mid-transaction.
REQ-018 SHALL discard any mrvalid_i arriving after reset until a new grant reaches WAIT.

Verification
REQ-019 Fetch only: ireq_i=1, iaddr_i=0x100, mready_i=1, mrvalid_i one cycle later with 0x00500093 -> mreq_o/maddr_o=0x100 and mwe_o=0; ivalid_o pulses in cycle 3 with irdata_o=0x00500093; istall_o=0 in that cycle.
REQ-020 Contention: ireq_i and dreq_i both set together (D read 0x2000) -> D served first, then I; istall_o=1 throughout D's transaction.
REQ-021 Starvation: STARVE_LIMIT=4, dreq_i re-asserted continuously with ireq_i=1 -> exactly 4 D grants, then an I grant, then the count restarts.
REQ-022 Backpressure: D write 0xDEADBEEF to 0x40 with byteen 4'b0011 and mready_i low for 5 cycles -> mreq_o and all m* outputs held stable for 6 cycles; dvalid_o after mrvalid_i.
REQ-023 Reset mid-WAIT: rst pulsed during WAIT, then mrvalid_i=1 -> no valid_o pulse; FSM is IDLE; next request served normally.
REQ-024 Back-to-back: dreq_i held high across dvalid_o with new address -> no regrant in the dvalid_o cycle; new grant on the following cycle.
